// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding and default width for the adder/subtractor family
package alu_pkg;
   localparam int DATA_W = 8;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake plus operand and result buses
interface serial_subtractor_if #(parameter int WIDTH = alu_pkg::DATA_W);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   modport master (output start, a, b, input busy, done, diff, bout);
   modport slave  (input start, a, b, output busy, done, diff, bout);
endinterface

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit x - y - bin cell
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one bit per clock
module serial_subtractor
   import alu_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input logic           clk,
   input logic           rst,
   serial_subtractor_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
   logic             br_q, br_d, bout_q, bout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fs_d, fs_bout;
   logic [WIDTH:0]   sh;
   full_subtractor u_fs (
      .x    (a_q[0]),
      .y    (b_q[0]),
      .bin  (br_q),
      .d    (fs_d),
      .bout (fs_bout)
   );
   assign sh       = {fs_d, res_q};
   assign bus.busy = state_q == SHIFT;
   assign bus.done = state_q == DONE;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
   // next-state: accept in IDLE, one bit step per SHIFT cycle, publish result entering DONE
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      unique case (state_q)
         IDLE: if (bus.start) begin
            a_d     = bus.a;
            b_d     = bus.b;
            br_d    = 1'b0;
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = fs_bout;
            res_d = sh[WIDTH:1];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               diff_d  = sh[WIDTH:1];
               bout_d  = fs_bout;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers; reset clears everything, aborting any run
   always_ff @(posedge clk)
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
      end
endmodule
